regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Buffers register-write requests from the writeback stage and drains them, one per cycle, into the 32x32 register file's single write port.
- Forwards pending (not yet committed) write data onto both read ports, so readers always see the youngest value.
- Sits directly upstream of regfile: owns its WriteRegister/WriteData/RegWrite inputs and muxes its ReadData1/ReadData2 outputs.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
WIDTH, 32, data width
AWIDTH, 5, register address width

Ports:
Clk  input  1  clock, rising-edge active
Reset_n  input  1  asynchronous, active-low reset
InValid  input  1  write request present
InReady  output  1  queue can accept a request
InRegister  input  AWIDTH  destination register of request
InData  input  WIDTH  data of request
DrainEn  input  1  write port available this cycle; low stalls draining
WriteRegister  output  AWIDTH  to regfile, head entry address
WriteData  output  WIDTH  to regfile, head entry data
RegWrite  output  1  to regfile, high when head is valid and DrainEn is high
ReadRegister1  input  AWIDTH  read address, port 1 (also driven to regfile)
ReadRegister2  input  AWIDTH  read address, port 2
RfReadData1  input  WIDTH  raw regfile port 1 data
RfReadData2  input  WIDTH  raw regfile port 2 data
ReadData1  output  WIDTH  forwarded port 1 data
ReadData2  output  WIDTH  forwarded port 2 data
Count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (Reset_n low, asynchronous): Count=0, read/write pointers=0, all entry valid bits cleared. Pending entries are discarded, including any reset mid-drain. RegWrite=0 immediately. WriteRegister/WriteData=0.
- Circular FIFO: write pointer, read pointer, Count register. Pointers wrap modulo DEPTH.
- Push: InValid && InReady at rising Clk edge.
  - InReady = (Count != DEPTH). Registered-state only; no combinational path from DrainEn.
  - Requests with InRegister==0 are accepted (handshake completes) but not enqueued; Count is unchanged.
- Pop: (Count != 0) && DrainEn at rising Clk edge. The regfile commits the head on the same edge.
- Write-port outputs are driven combinationally from the head entry: RegWrite = (Count!=0) && DrainEn.
- Simultaneous push and pop: Count unchanged. Both pointers advance.
- Push while full is impossible because InReady=0. Full with pop: the slot frees only on the following cycle.
- Forwarding, evaluated per port, fully combinational:
  - If ReadRegisterN==0: ReadDataN=0.
  - Else, if any valid entry matches ReadRegisterN: ReadDataN = data of the youngest matching entry (nearest to the write pointer).
  - Else: ReadDataN = RfReadDataN.
  - The head entry being drained this cycle still forwards, because the regfile has not yet updated.
  - An incoming request that has not yet been accepted does not forward. Latency from acceptance to forwarding visibility is 1 cycle.
- Ordering: commits to the regfile occur in acceptance order. Duplicate addresses are allowed; the last one wins.
- No X may propagate on ReadDataN when entries are invalid. Invalid entries must be masked out by their valid bits.

Decomposition:
- Shared package regfile_pkg: WIDTH/AWIDTH constants, REG_ZERO=5'd0, and a write-request struct {addr, data}.
- One sub-module, rfq_forward_mux: takes DEPTH entries plus valid bits plus a read address, and produces a hit flag and the youngest data.
  - Instantiated twice, once per read port.
  - Age order is derived from the read pointer.

Test Plan:
1. Reset, then push (r2,42) with DrainEn=0. Next cycle: Count=1, RegWrite=0, ReadRegister1=2 gives ReadData1=42 while RfReadData1=0.
2. Push (r3,17), (r3,18), (r3,19) back-to-back with DrainEn=0. ReadData1 for r3 is 19. Push a 4th entry (r5,5), then Count=4 and InReady=0. InValid held high with (r6,6) is not accepted.
3. From full, raise DrainEn for 4 cycles. WriteRegister/WriteData sequence is r3/17, r3/18, r3/19, r5/5 with RegWrite=1 each cycle. Then Count=0 and RegWrite=0.
4. Push (r0,18). InReady=1, Count stays 0, RegWrite never asserts. ReadRegister1=2'd0 gives ReadData1=0 even when RfReadData1=32'hFFFFFFFF.
5. With Count=2 and DrainEn=1, push (r7,20) on the same cycle as a pop. Count stays 2 and the pointers wrap past DEPTH-1 correctly. ReadRegister2=7 gives 20 on the next cycle.
6. With 3 entries queued, assert Reset_n=0 between clock edges. RegWrite=0 and Count=0 immediately. After release, ReadData1 equals RfReadData1.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and write-request type
package regfile_pkg;

    localparam int WIDTH  = 32;
    localparam int AWIDTH = 5;

    localparam logic [AWIDTH-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_req_t;

endpackage

// File: rtl/rfq_forward_mux.sv
// rtl/rfq_forward_mux.sv - picks the youngest valid queue entry matching a read address
module rfq_forward_mux #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 5,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][AWIDTH-1:0] addr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]  data_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [PW-1:0]                rd_ptr_i,
    input  logic [AWIDTH-1:0]            rd_addr_i,
    output logic                         hit_o,
    output logic [WIDTH-1:0]             data_o
);

    logic [PW-1:0] idx;

    // Walk from oldest (read pointer) to youngest so the last match wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_i + PW'(k);
            if (valid_i[idx] && (addr_i[idx] == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - write-request FIFO in front of the regfile with read forwarding
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = regfile_pkg::WIDTH,
    parameter int AWIDTH = regfile_pkg::AWIDTH
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [AWIDTH-1:0]        InRegister,
    input  logic [WIDTH-1:0]         InData,
    input  logic                     DrainEn,
    output logic [AWIDTH-1:0]        WriteRegister,
    output logic [WIDTH-1:0]         WriteData,
    output logic                     RegWrite,
    input  logic [AWIDTH-1:0]        ReadRegister1,
    input  logic [AWIDTH-1:0]        ReadRegister2,
    input  logic [WIDTH-1:0]         RfReadData1,
    input  logic [WIDTH-1:0]         RfReadData2,
    output logic [WIDTH-1:0]         ReadData1,
    output logic [WIDTH-1:0]         ReadData2,
    output logic [$clog2(DEPTH):0]   Count
);

    import regfile_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [DEPTH-1:0]               valid_q, valid_d;
    logic [DEPTH-1:0][AWIDTH-1:0]   addr_q, addr_d;
    logic [DEPTH-1:0][WIDTH-1:0]    data_q, data_d;
    logic                           push, enq, pop;
    logic                           hit1, hit2;
    logic [WIDTH-1:0]               fwd1, fwd2;

    assign InReady = (count_q != CW'(DEPTH));
    assign push    = InValid && InReady;
    // Writes to the zero register complete the handshake but never occupy a slot.
    assign enq     = push && (InRegister != AWIDTH'(REG_ZERO));
    assign pop     = (count_q != '0) && DrainEn;

    assign RegWrite      = pop;
    assign WriteRegister = addr_q[rd_ptr_q];
    assign WriteData     = data_q[rd_ptr_q];
    assign Count         = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = InRegister;
            data_d[wr_ptr_q]  = InData;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    rfq_forward_mux #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AWIDTH(AWIDTH), .PW(PW)) u_fwd1 (
        .addr_i    (addr_q),
        .data_i    (data_q),
        .valid_i   (valid_q),
        .rd_ptr_i  (rd_ptr_q),
        .rd_addr_i (ReadRegister1),
        .hit_o     (hit1),
        .data_o    (fwd1)
    );

    rfq_forward_mux #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AWIDTH(AWIDTH), .PW(PW)) u_fwd2 (
        .addr_i    (addr_q),
        .data_i    (data_q),
        .valid_i   (valid_q),
        .rd_ptr_i  (rd_ptr_q),
        .rd_addr_i (ReadRegister2),
        .hit_o     (hit2),
        .data_o    (fwd2)
    );

    assign ReadData1 = (ReadRegister1 == AWIDTH'(REG_ZERO)) ? '0 : (hit1 ? fwd1 : RfReadData1);
    assign ReadData2 = (ReadRegister2 == AWIDTH'(REG_ZERO)) ? '0 : (hit2 ? fwd2 : RfReadData2);

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - scoreboard bench for regfile_write_queue
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegister;
    logic [31:0] InData;
    logic        DrainEn;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic [31:0] RfReadData1, RfReadData2;
    logic [31:0] ReadData1, ReadData2;
    logic [2:0]  Count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rf_model [32];
    logic [31:0] arch [32];
    int          mcount = 0;
    int          checks = 0;
    int          errors = 0;
    bit          commit_valid = 1'b0;
    req_t        commit_req;

    regfile_write_queue #(.DEPTH(DEPTH), .WIDTH(32), .AWIDTH(5)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .InValid       (InValid),
        .InReady       (InReady),
        .InRegister    (InRegister),
        .InData        (InData),
        .DrainEn       (DrainEn),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .RfReadData1   (RfReadData1),
        .RfReadData2   (RfReadData2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .Count         (Count)
    );

    always #5 Clk = ~Clk;

    assign RfReadData1 = rf_model[ReadRegister1];
    assign RfReadData2 = rf_model[ReadRegister2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : arch[a];
    endfunction

    // Monitor: every commit the DUT presents must be the oldest accepted request.
    always @(negedge Clk) begin
        if (Reset_n && RegWrite) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 32'd1, 32'd0);
            end else begin
                commit_req = exp_q.pop_front();
                chk("commit_addr", 32'(WriteRegister), 32'(commit_req.a));
                chk("commit_data", WriteData, commit_req.d);
                commit_valid = 1'b1;
            end
        end
    end

    always @(posedge Clk) begin
        if (commit_valid) begin
            rf_model[commit_req.a] = commit_req.d;
            commit_valid = 1'b0;
        end
    end

    task automatic step(input bit v, input logic [4:0] r, input logic [31:0] d,
                        input bit dr, input logic [4:0] a1, input logic [4:0] a2);
        bit acc, enq, pop;
        @(posedge Clk);
        #1;
        InValid = v; InRegister = r; InData = d; DrainEn = dr;
        ReadRegister1 = a1; ReadRegister2 = a2;
        @(negedge Clk);
        chk("count", 32'(Count), 32'(mcount));
        chk("in_ready", 32'(InReady), 32'(mcount != DEPTH));
        chk("read_data1", ReadData1, exp_rd(a1));
        chk("read_data2", ReadData2, exp_rd(a2));
        acc = v && (mcount != DEPTH);
        enq = acc && (r != 5'd0);
        pop = (mcount != 0) && dr;
        if (enq) begin
            exp_q.push_back('{a: r, d: d});
            arch[r] = d;
        end
        mcount = mcount + int'(enq) - int'(pop);
    endtask

    initial begin
        Reset_n = 1'b0;
        InValid = 1'b0; InRegister = '0; InData = '0; DrainEn = 1'b0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        for (int i = 0; i < 32; i++) rf_model[i] = $urandom;
        rf_model[0] = 32'hFFFF_FFFF;
        rf_model[2] = 32'd0;
        for (int i = 0; i < 32; i++) arch[i] = rf_model[i];
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_count", 32'(Count), 32'd0);
        chk("reset_regwrite", 32'(RegWrite), 32'd0);
        chk("reset_wreg", 32'(WriteRegister), 32'd0);
        chk("reset_wdata", WriteData, 32'd0);
        chk("reset_inready", 32'(InReady), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Single push is forwarded the next cycle while the regfile still holds 0.
        step(1, 5'd2, 32'd42, 0, 5'd2, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd2, 5'd2);
        step(0, 5'd0, 32'd0, 1, 5'd2, 5'd3);

        // Duplicates, youngest wins, then fill and hold a blocked request.
        step(1, 5'd3, 32'd17, 0, 5'd3, 5'd2);
        step(1, 5'd3, 32'd18, 0, 5'd3, 5'd2);
        step(1, 5'd3, 32'd19, 0, 5'd3, 5'd3);
        step(1, 5'd5, 32'd5,  0, 5'd3, 5'd5);
        step(1, 5'd6, 32'd6,  0, 5'd6, 5'd3);
        step(1, 5'd6, 32'd6,  0, 5'd6, 5'd5);

        // Drain from full in acceptance order.
        for (int i = 0; i < 4; i++) step(0, 5'd0, 32'd0, 1, 5'd3, 5'd5);
        step(0, 5'd0, 32'd0, 1, 5'd3, 5'd5);

        // Zero-register write is acknowledged but dropped.
        step(1, 5'd0, 32'd18, 1, 5'd0, 5'd0);
        step(0, 5'd0, 32'd0, 1, 5'd0, 5'd3);

        // Push coinciding with pop at Count=2, across the pointer wrap.
        step(1, 5'd8, 32'd80, 0, 5'd8, 5'd7);
        step(1, 5'd9, 32'd90, 0, 5'd8, 5'd9);
        step(1, 5'd7, 32'd20, 1, 5'd7, 5'd7);
        step(0, 5'd0, 32'd0, 0, 5'd9, 5'd7);
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'd0, 1, 5'd8, 5'd7);

        // Asynchronous reset with three pending entries, mid-drain.
        step(1, 5'd4, 32'hAAAA_0004, 0, 5'd4, 5'd0);
        step(1, 5'd10, 32'hAAAA_000A, 0, 5'd4, 5'd10);
        step(1, 5'd4, 32'hBBBB_0004, 0, 5'd4, 5'd10);
        @(posedge Clk);
        #1;
        DrainEn = 1'b1; ReadRegister1 = 5'd4; InValid = 1'b0;
        #1;
        Reset_n = 1'b0;
        #1;
        chk("async_regwrite", 32'(RegWrite), 32'd0);
        chk("async_count", 32'(Count), 32'd0);
        chk("async_wdata", WriteData, 32'd0);
        DrainEn = 1'b0;
        exp_q.delete();
        mcount = 0;
        for (int i = 0; i < 32; i++) arch[i] = rf_model[i];
        @(negedge Clk);
        Reset_n = 1'b1;
        step(0, 5'd0, 32'd0, 0, 5'd4, 5'd10);
        chk("post_reset_rd1", ReadData1, RfReadData1);

        // Randomized traffic over a small register set to force collisions.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(0, 5'd0, 32'd0, 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
